filter_buffer_db: RTL and testbench
===================================

Name: filter_buffer_db

Overview:
Double-buffered, parametrised filter-weight buffer for the convolver. Weights stream into a shadow bank through a valid/ready handshake. On a swap request the full shadow bank is copied into the active bank, which drives all KSIZE*KSIZE taps in parallel to the MAC array. The next filter can load while the current one is in use.

Parameters:
WID, `WID_FILTER, bit width of one weight
KSIZE, 3, kernel edge; TAPS = KSIZE*KSIZE (localparam)
CNT_W, $clog2(KSIZE*KSIZE+1), width of load counter (localparam)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
in_valid  input  1  weight word valid
in_ready  output  1  buffer can accept a word
in_data  input  WID  weight word; first accepted word = tap 0
swap  input  1  request: shadow -> active
swap_ack  output  1  one-cycle pulse, swap performed
taps_out  output  TAPS*WID  active bank; tap i at [i*WID +: WID]
taps_valid  output  1  active bank holds a complete filter
shadow_full  output  1  shadow bank holds TAPS words
load_count  output  CNT_W  words accepted into shadow bank

Behaviour:
- Reset (rst==0 at a clk edge): taps_out=0, taps_valid=0, swap_ack=0, shadow_full=0, load_count=0, shadow bank=0, state=LOAD. Reset applied mid-load or mid-swap discards everything. The first cycle after reset is a normal LOAD cycle.
- FSM states: LOAD, FULL.
  - LOAD: in_ready=1. A word is accepted when in_valid&&in_ready; it writes shadow[load_count], then load_count increments.
  - LOAD -> FULL: on the edge that accepts word TAPS-1; load_count becomes TAPS.
  - FULL: in_ready=0, shadow_full=1. in_valid is ignored and no data is lost upstream.
  - FULL -> LOAD: on the edge where swap==1. active <= shadow; taps_valid <= 1; swap_ack <= 1 for exactly one cycle; load_count <= 0; shadow_full <= 0. The shadow contents are not cleared; they are overwritten by the next load.
- swap in LOAD: ignored, no ack, active bank unchanged.
- swap on the same edge as the final word is accepted: not honoured. The swap must be re-asserted or held; it is taken on the next edge, giving 1-cycle minimum latency from the last word to swap.
- swap held high continuously: one swap per completed shadow fill. Swaps are therefore separated by at least TAPS+1 cycles.
- in_ready is a registered state decode, not combinational on in_valid or swap.
- taps_out is stable between swaps and changes only on a swap_ack edge.
- Latency:
  - word accepted -> visible in the shadow: 1 cycle.
  - swap sampled -> taps_out updated and swap_ack high: 1 cycle.
- Data is stored unmodified; no arithmetic. load_count saturates by construction at TAPS.

Optional Feature:
Macro FILTER_BUF_FLIP_EN.
- Defined: adds input port flip (1 bit), sampled with swap. If flip==1 at the swap edge, active[i] <= shadow[TAPS-1-i], a 180-degree kernel rotation for transposed convolution. If flip==0, the copy is straight.
- Undefined: no flip port; the copy is always straight. Behaviour is identical to flip==0.

Decomposition:
- Shared header (header.vh): `WID_FILTER, default KSIZE (`KSIZE_FILTER), state encodings FB_LOAD/FB_FULL.
- One sub-module, weight_bank: TAPS x WID register array with an indexed write port, a sync active-low clear, and flat parallel output. It is instantiated twice, as shadow and active; the active instance uses a full-bank parallel load.
- The FSM and counter live in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=1, taps_out=0, taps_valid=0, load_count=0 after release.
- Basic load/swap, KSIZE=3, WID=8: stream 1..9 with in_valid=1 every cycle -> shadow_full on cycle 9. Pulse swap -> next cycle swap_ack=1 and taps_out = {9,8,...,1} (tap0=1), taps_valid=1.
- Backpressure: after 9 words keep in_valid=1 with data 0xAA -> in_ready=0, load_count stays 9. After the swap, 0xAA is accepted as the new tap 0.
- Early/simultaneous swap: swap=1 at word 5 -> no ack, taps_out unchanged. Swap on the 9th-word edge -> no ack that edge; swap held -> ack next cycle.
- Overlap: load filter B (10..18) while A is active -> taps_out stays A until swap, then becomes B in one edge.
- Mid-load reset and KSIZE=5, WID=16: reset after 12 of 25 words -> load_count=0, taps_valid=0. A full 25-word reload then swaps correctly. With FILTER_BUF_FLIP_EN and flip=1, tap0=25, tap24=1.

Source files
------------

// File: rtl/filter_buffer_db_pkg.sv
// Shared definitions for the double-buffered filter-weight buffer:
// default weight width and kernel edge, plus the load/full state encoding.
package filter_buffer_db_pkg;

    // Default width of one filter weight.
    localparam int WID_FILTER   = 8;
    // Default kernel edge; the buffer holds KSIZE*KSIZE taps.
    localparam int KSIZE_FILTER = 3;

    // LOAD: shadow bank accepts words. FULL: shadow complete, waiting for swap.
    typedef enum logic {
        FB_LOAD = 1'b0,
        FB_FULL = 1'b1
    } fb_state_e;

    // Number of taps for a square kernel of the given edge.
    function automatic int taps_of(input int ksize);
        return ksize * ksize;
    endfunction

endpackage

// File: rtl/filter_buffer_db_weight_bank.sv
// weight_bank: TAPS x WID register array with an indexed single-word write
// port, a whole-bank parallel load, a synchronous active-low clear and a flat
// parallel output (tap i at [i*WID +: WID]).
// Priority: clear over parallel load over indexed write.
module weight_bank #(
    parameter int WID  = 8,
    parameter int TAPS = 9,
    parameter int AW   = 4
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [WID-1:0]      wdata,
    input  logic                load,
    input  logic [TAPS*WID-1:0] load_data,
    output logic [TAPS*WID-1:0] bank_out
);

    logic [WID-1:0] regs [TAPS];

    // Register array update: clear, full-bank load, or one indexed word.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < TAPS; i++) begin
                regs[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < TAPS; i++) begin
                regs[i] <= load_data[i*WID +: WID];
            end
        end else if (we) begin
            // Compare against every slot so an address past TAPS-1 writes nothing.
            for (int i = 0; i < TAPS; i++) begin
                if (waddr == AW'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Flatten the array onto the parallel output bus.
    for (genvar g = 0; g < TAPS; g++) begin : g_out
        assign bank_out[g*WID +: WID] = regs[g];
    end

endmodule

// File: rtl/filter_buffer_db.sv
// filter_buffer_db: double-buffered filter-weight buffer for the convolver.
// Weights stream into a shadow bank over a valid/ready handshake; a swap
// copies the complete shadow bank into the active bank that feeds all taps
// to the MAC array, so the next filter loads while the current one is used.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is a decode of the registered state only (high in LOAD), so it
// never depends combinationally on in_valid or swap; upstream holds its word
// while in_ready is low and nothing is lost.
//
// Optional build macro FILTER_BUF_FLIP_EN adds input 'flip', sampled with
// swap: when high the copy is rotated 180 degrees (active[i] = shadow[TAPS-1-i]).
// Without the macro the copy is always straight.
module filter_buffer_db
    import filter_buffer_db_pkg::*;
#(
    parameter  int WID   = WID_FILTER,
    parameter  int KSIZE = KSIZE_FILTER,
    localparam int TAPS  = KSIZE * KSIZE,
    localparam int CNT_W = $clog2(KSIZE * KSIZE + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WID-1:0]      in_data,
    input  logic                swap,
`ifdef FILTER_BUF_FLIP_EN
    input  logic                flip,
`endif
    output logic                swap_ack,
    output logic [TAPS*WID-1:0] taps_out,
    output logic                taps_valid,
    output logic                shadow_full,
    output logic [CNT_W-1:0]    load_count,
    output fb_state_e           dbg_state
);

    fb_state_e           state_q;
    fb_state_e           state_d;
    logic                accept;
    logic                do_swap;
    logic                flip_sel;
    logic [CNT_W-1:0]    count_q;
    logic                ack_q;
    logic                valid_q;
    logic [TAPS*WID-1:0] shadow_flat;
    logic [TAPS*WID-1:0] copy_flat;

`ifdef FILTER_BUF_FLIP_EN
    assign flip_sel = flip;
`else
    assign flip_sel = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FB_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the accept/swap strobes derived from the current state.
    // A swap on the edge that accepts the last word is not seen, because the
    // FSM is still in LOAD on that edge.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        do_swap = 1'b0;
        case (state_q)
            FB_LOAD: begin
                accept = in_valid;
                if (in_valid && (count_q == CNT_W'(TAPS - 1))) begin
                    state_d = FB_FULL;
                end
            end
            FB_FULL: begin
                do_swap = swap;
                if (swap) begin
                    state_d = FB_LOAD;
                end
            end
            default: begin
                state_d = FB_LOAD;
            end
        endcase
    end

    // Load counter: write pointer into the shadow bank, stops at TAPS because
    // the FSM leaves LOAD on the last word and only a swap restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (do_swap) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Swap acknowledge pulse and "active bank holds a filter" flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ack_q <= do_swap;
            if (do_swap) begin
                valid_q <= 1'b1;
            end
        end
    end

    // Shadow-to-active copy, straight or rotated by 180 degrees.
    for (genvar g = 0; g < TAPS; g++) begin : g_copy
        assign copy_flat[g*WID +: WID] = flip_sel ? shadow_flat[(TAPS-1-g)*WID +: WID]
                                                  : shadow_flat[g*WID +: WID];
    end

    weight_bank #(
        .WID  (WID),
        .TAPS (TAPS),
        .AW   (CNT_W)
    ) u_shadow (
        .clk       (clk),
        .clr_n     (rst),
        .we        (accept),
        .waddr     (count_q),
        .wdata     (in_data),
        .load      (1'b0),
        .load_data ('0),
        .bank_out  (shadow_flat)
    );

    weight_bank #(
        .WID  (WID),
        .TAPS (TAPS),
        .AW   (CNT_W)
    ) u_active (
        .clk       (clk),
        .clr_n     (rst),
        .we        (1'b0),
        .waddr     ('0),
        .wdata     ('0),
        .load      (do_swap),
        .load_data (copy_flat),
        .bank_out  (taps_out)
    );

    assign in_ready    = (state_q == FB_LOAD);
    assign shadow_full = (state_q == FB_FULL);
    assign swap_ack    = ack_q;
    assign taps_valid  = valid_q;
    assign load_count  = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_filter_buffer_db.sv
// Bench for filter_buffer_db: a 3x3/8-bit instance driven from a per-cycle
// vector table plus a random tail, and a 5x5/16-bit instance driven by a
// hand-written mid-load reset / reload / swap sequence. Expected active banks
// go into per-instance queues when a swap is driven and are popped when
// swap_ack appears. Build with FILTER_BUF_FLIP_EN to exercise the rotation.
module tb_filter_buffer_db;
    import filter_buffer_db_pkg::*;

    localparam int W3 = 8;
    localparam int K3 = 3;
    localparam int T3 = 9;
    localparam int C3 = 4;
    localparam int W5 = 16;
    localparam int K5 = 5;
    localparam int T5 = 25;
    localparam int C5 = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 3x3 instance signals
    logic               rst3, v3, sw3, rdy3, ack3, tv3, full3;
    logic [W3-1:0]      d3;
    logic [T3*W3-1:0]   taps3;
    logic [C3-1:0]      cnt3;
    fb_state_e          st3;
    // 5x5 instance signals
    logic               rst5, v5, sw5, rdy5, ack5, tv5, full5;
    logic [W5-1:0]      d5;
    logic [T5*W5-1:0]   taps5;
    logic [C5-1:0]      cnt5;
    fb_state_e          st5;
`ifdef FILTER_BUF_FLIP_EN
    logic               fl3, fl5;
`endif

    filter_buffer_db #(.WID(W3), .KSIZE(K3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
        .swap(sw3),
`ifdef FILTER_BUF_FLIP_EN
        .flip(fl3),
`endif
        .swap_ack(ack3), .taps_out(taps3), .taps_valid(tv3),
        .shadow_full(full3), .load_count(cnt3), .dbg_state(st3)
    );

    filter_buffer_db #(.WID(W5), .KSIZE(K5)) dut5 (
        .clk(clk), .rst(rst5), .in_valid(v5), .in_ready(rdy5), .in_data(d5),
        .swap(sw5),
`ifdef FILTER_BUF_FLIP_EN
        .flip(fl5),
`endif
        .swap_ack(ack5), .taps_out(taps5), .taps_valid(tv5),
        .shadow_full(full5), .load_count(cnt5), .dbg_state(st5)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [T3*W3-1:0] exp3_q[$];
    logic [T5*W5-1:0] exp5_q[$];

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock for the 3x3 instance, then sample and serve the scoreboard.
    task automatic tick3();
        @(posedge clk);
        #1;
        if (ack3) begin
            if (exp3_q.size() == 0) check("sb3_unexpected_ack", 1, 0);
            else check("sb3_taps", taps3, exp3_q.pop_front());
        end
    endtask

    task automatic tick5();
        @(posedge clk);
        #1;
        if (ack5) begin
            if (exp5_q.size() == 0) check("sb5_unexpected_ack", 1, 0);
            else check("sb5_taps", taps5, exp5_q.pop_front());
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic          v;
        logic [W3-1:0] d;
        logic          sw;
        logic          rdy;
        logic [C3-1:0] cnt;
        logic          full;
        logic          ack;
        logic          tv;
    } row_t;

    function automatic row_t mk(input logic v, input logic [W3-1:0] d, input logic sw,
                                input logic rdy, input logic [C3-1:0] cnt,
                                input logic full, input logic ack, input logic tv);
        row_t r;
        r.v = v; r.d = d; r.sw = sw; r.rdy = rdy; r.cnt = cnt;
        r.full = full; r.ack = ack; r.tv = tv;
        return r;
    endfunction

    localparam int NROWS = 24;
    row_t tbl[NROWS];

    // Reference model of the 3x3 shadow/active banks.
    logic [W3-1:0]    m_sh[T3];
    logic [T3*W3-1:0] m_act;
    logic [T3*W3-1:0] m_pack;
    logic             m_rdy;
    int               m_cnt;
    logic [T5*W5-1:0] e5;
    logic [W5-1:0]    rnd_w;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Filter A: words 1..9, early swap at word 5, swap on the 9th-word edge.
        for (int r = 0; r < 8; r++)
            tbl[r] = mk(1'b1, W3'(r + 1), (r == 4), 1'b1, C3'(r + 1), 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 8'd9,   1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        // Backpressure: 0xAA held while full.
        tbl[9]  = mk(1'b1, 8'hAA, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 8'hAA, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        // Filter B: 0xAA as tap 0, then 11..18 while A is active.
        tbl[12] = mk(1'b1, 8'hAA, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        for (int r = 13; r < 20; r++)
            tbl[r] = mk(1'b1, W3'(r - 2), 1'b0, 1'b1, C3'(r - 11), 1'b0, 1'b0, 1'b1);
        tbl[20] = mk(1'b1, 8'd18,  1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1);
        tbl[21] = mk(1'b0, 8'd0,   1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        // Held swap in LOAD does nothing; next word loads normally.
        tbl[22] = mk(1'b0, 8'd0,   1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        tbl[23] = mk(1'b1, 8'h55,  1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);

        // ---- reset of both instances, in_valid high throughout ----
        rst3 = 1'b0; v3 = 1'b1; d3 = 8'h77; sw3 = 1'b0;
        rst5 = 1'b0; v5 = 1'b0; d5 = '0;    sw5 = 1'b0;
`ifdef FILTER_BUF_FLIP_EN
        fl3 = 1'b0; fl5 = 1'b0;
`endif
        repeat (3) tick3();
        check("rst_in_ready", rdy3, 1);
        check("rst_taps_out", taps3, 0);
        check("rst_taps_valid", tv3, 0);
        check("rst_load_count", cnt3, 0);
        check("rst_shadow_full", full3, 0);
        check("rst_swap_ack", ack3, 0);
        check("rst_state", st3, FB_LOAD);
        rst3 = 1'b1; v3 = 1'b0;

        // ---- table-driven run on the 3x3 instance ----
        for (int i = 0; i < T3; i++) m_sh[i] = '0;
        m_act = '0; m_rdy = 1'b1; m_cnt = 0;
        for (int r = 0; r < NROWS; r++) begin
            v3 = tbl[r].v; d3 = tbl[r].d; sw3 = tbl[r].sw;
            if (tbl[r].v && m_rdy) begin
                m_sh[m_cnt] = tbl[r].d;
                m_cnt++;
            end
            if (tbl[r].ack) begin
                for (int i = 0; i < T3; i++) m_pack[i*W3 +: W3] = m_sh[i];
                exp3_q.push_back(m_pack);
                m_act = m_pack;
                m_cnt = 0;
            end
            tick3();
            check($sformatf("row%0d_in_ready", r), rdy3, tbl[r].rdy);
            check($sformatf("row%0d_load_count", r), cnt3, tbl[r].cnt);
            check($sformatf("row%0d_shadow_full", r), full3, tbl[r].full);
            check($sformatf("row%0d_swap_ack", r), ack3, tbl[r].ack);
            check($sformatf("row%0d_taps_valid", r), tv3, tbl[r].tv);
            check($sformatf("row%0d_taps_out", r), taps3, m_act);
            m_rdy = tbl[r].rdy;
        end

        // ---- random tail: finish filter C (tap 0 = 0x55) and swap ----
        for (int k = 1; k < T3; k++) begin
            rnd_w = W5'($urandom_range(0, 255));
            m_sh[k] = rnd_w[W3-1:0];
            v3 = 1'b1; d3 = rnd_w[W3-1:0]; sw3 = 1'b0;
            tick3();
            check($sformatf("rnd%0d_in_ready", k), rdy3, (k < T3 - 1));
        end
        v3 = 1'b0; sw3 = 1'b1;
        for (int i = 0; i < T3; i++) m_pack[i*W3 +: W3] = m_sh[i];
        exp3_q.push_back(m_pack);
        tick3();
        check("rnd_swap_ack", ack3, 1);
        sw3 = 1'b0;
        tick3();
        check("rnd_ack_pulse", ack3, 0);
        check("rnd_taps_stable", taps3, m_pack);
        check("sb3_empty", exp3_q.size(), 0);

        // ---- 5x5 / 16-bit: mid-load reset, full reload, swap ----
        rst5 = 1'b1; v5 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            d5 = W5'(k);
            tick5();
        end
        check("k5_partial_count", cnt5, 12);
        rst5 = 1'b0; d5 = 16'd99;
        tick5();
        check("k5_rst_count", cnt5, 0);
        check("k5_rst_taps_valid", tv5, 0);
        check("k5_rst_in_ready", rdy5, 1);
        check("k5_rst_taps_out", taps5, 0);
        rst5 = 1'b1;
        for (int k = 1; k <= T5; k++) begin
            d5 = W5'(k);
            tick5();
        end
        check("k5_full", full5, 1);
        check("k5_in_ready", rdy5, 0);
        check("k5_count", cnt5, T5);
        check("k5_state", st5, FB_FULL);
        v5 = 1'b0; sw5 = 1'b1;
`ifdef FILTER_BUF_FLIP_EN
        fl5 = 1'b1;
        for (int i = 0; i < T5; i++) e5[i*W5 +: W5] = W5'(T5 - i);
`else
        for (int i = 0; i < T5; i++) e5[i*W5 +: W5] = W5'(i + 1);
`endif
        exp5_q.push_back(e5);
        tick5();
        check("k5_swap_ack", ack5, 1);
        check("k5_taps_valid", tv5, 1);
        check("k5_tap0", taps5[0 +: W5], e5[0 +: W5]);
        check("k5_tap24", taps5[24*W5 +: W5], e5[24*W5 +: W5]);
        sw5 = 1'b0;
        tick5();
        check("k5_ack_pulse", ack5, 0);
        check("k5_taps_stable", taps5, e5);
        check("sb5_empty", exp5_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
